// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the two-master cache bus arbiter.
// No logic: enums, owner type, default bus widths, watchdog counter width.
// Backpressure: not applicable.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // 0 = m0 (I-cache), 1 = m1 (D-cache)
  typedef logic owner_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  function automatic int cnt_width(input int timeout_cyc);
    return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/cache_arb_if.sv
// Bundle of both cache-side request ports and the shared memory port.
// Latency: none (wires only).
// Backpressure: strobe held by each requester until its ready pulse.
interface cache_arb_if #(
  parameter int ADDR_W = cache_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = cache_arb_pkg::DEF_DATA_W
);
  logic              m0_strobe;
  logic [ADDR_W-1:0] m0_address;
  logic [DATA_W-1:0] m0_data_in;
  logic              m0_rw;
  logic [DATA_W-1:0] m0_data_out;
  logic              m0_ready;
  logic              m0_err;

  logic              m1_strobe;
  logic [ADDR_W-1:0] m1_address;
  logic [DATA_W-1:0] m1_data_in;
  logic              m1_rw;
  logic [DATA_W-1:0] m1_data_out;
  logic              m1_ready;
  logic              m1_err;

  logic              S_strobe;
  logic [ADDR_W-1:0] S_address;
  logic [DATA_W-1:0] S_data_out;
  logic              S_rw;
  logic [DATA_W-1:0] S_data_in;
  logic              S_ready;

  // master: the arbiter itself (drives memory requests and cache responses)
  modport master (
    input  m0_strobe, m0_address, m0_data_in, m0_rw,
    output m0_data_out, m0_ready, m0_err,
    input  m1_strobe, m1_address, m1_data_in, m1_rw,
    output m1_data_out, m1_ready, m1_err,
    output S_strobe, S_address, S_data_out, S_rw,
    input  S_data_in, S_ready
  );

  // slave: the environment (both caches plus the memory)
  modport slave (
    output m0_strobe, m0_address, m0_data_in, m0_rw,
    input  m0_data_out, m0_ready, m0_err,
    output m1_strobe, m1_address, m1_data_in, m1_rw,
    input  m1_data_out, m1_ready, m1_err,
    input  S_strobe, S_address, S_data_out, S_rw,
    output S_data_in, S_ready
  );

endinterface

// File: rtl/cache_arb_rr.sv
// Two-way round-robin pick: the favoured requester wins when both ask.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is consumed.
module cache_arb_rr
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     favour,
  output logic       grant_valid,
  output owner_t     grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = favour;
    if (!req[favour]) begin
      grant_id = ~favour;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one memory port between I-cache (m0) and D-cache (m1); optional counters via CACHE_ARB_STATS_EN.
// Latency: grant cycle 0, BUSY from cycle 1, ready one cycle after S_ready (min 3 cycles strobe-to-ready).
// Backpressure: one transaction in flight; losing strobe stays high and is granted in the next IDLE.
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  cache_arb_if.master bus
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [31:0] stat_grant0,
  output logic [31:0] stat_grant1,
  output logic [31:0] stat_timeout
`endif
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
  } xact_t;

  arb_state_e        state_q;
  arb_state_e        state_d;
  owner_t            owner_q;
  owner_t            fav_q;
  xact_t             xact_q;
  xact_t             xact_sel;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [1:0]        mask_q;
  logic [DATA_W-1:0] m0_dout_q;
  logic [DATA_W-1:0] m1_dout_q;

  logic [1:0] req;
  logic       grant_vld;
  owner_t     grant_id;
  logic       take;
  logic       finish_ok;
  logic       abort;
  logic       done_m0;
  logic       done_m1;

  // The previous owner is still holding strobe in the cycle right after its
  // ready pulse; masking it avoids granting a stale request.
  assign req = {bus.m1_strobe, bus.m0_strobe} & ~mask_q;

  cache_arb_rr u_rr (
    .req         (req),
    .favour      (fav_q),
    .grant_valid (grant_vld),
    .grant_id    (grant_id)
  );

  always_comb begin
    xact_sel = '0;
    if (grant_id) begin
      xact_sel.addr = bus.m1_address;
      xact_sel.data = bus.m1_data_in;
      xact_sel.rw   = bus.m1_rw;
    end else begin
      xact_sel.addr = bus.m0_address;
      xact_sel.data = bus.m0_data_in;
      xact_sel.rw   = bus.m0_rw;
    end
  end

  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    finish_ok = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          take    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A late S_ready on the last allowed cycle still completes normally.
        if (bus.S_ready) begin
          finish_ok = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      fav_q     <= 1'b0;
      xact_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      mask_q    <= '0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= '0;

      if (take) begin
        owner_q <= grant_id;
        xact_q  <= xact_sel;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end

      if (state_q == BUSY && cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (finish_ok && xact_q.rw) begin
        if (owner_q) begin
          m1_dout_q <= bus.S_data_in;
        end else begin
          m0_dout_q <= bus.S_data_in;
        end
      end

      if (abort) begin
        err_q <= 1'b1;
        if (owner_q) begin
          m1_dout_q <= '0;
        end else begin
          m0_dout_q <= '0;
        end
      end

      if (state_q == DONE) begin
        fav_q           <= ~owner_q;
        mask_q[owner_q] <= 1'b1;
      end
    end
  end

  assign done_m0 = (state_q == DONE) && (owner_q == 1'b0);
  assign done_m1 = (state_q == DONE) && (owner_q == 1'b1);

  assign bus.S_strobe    = (state_q == BUSY);
  assign bus.S_address   = xact_q.addr;
  assign bus.S_data_out  = xact_q.data;
  assign bus.S_rw        = xact_q.rw;

  assign bus.m0_ready    = done_m0;
  assign bus.m0_err      = done_m0 && err_q;
  assign bus.m0_data_out = m0_dout_q;
  assign bus.m1_ready    = done_m1;
  assign bus.m1_err      = done_m1 && err_q;
  assign bus.m1_data_out = m1_dout_q;

`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0  <= '0;
      stat_grant1  <= '0;
      stat_timeout <= '0;
    end else begin
      if (take && !grant_id && stat_grant0 != 32'hFFFF_FFFF) begin
        stat_grant0 <= stat_grant0 + 32'd1;
      end
      if (take && grant_id && stat_grant1 != 32'hFFFF_FFFF) begin
        stat_grant1 <= stat_grant1 + 32'd1;
      end
      if (abort && stat_timeout != 32'hFFFF_FFFF) begin
        stat_timeout <= stat_timeout + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: per-cycle vector table plus hand-written
// sequences for long waits, watchdog abort and mid-transaction reset.
module tb_cache_bus_arbiter;

  localparam int   AW = 32;
  localparam int   DW = 32;
  localparam logic T  = 1'b1;
  localparam logic F  = 1'b0;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cache_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef CACHE_ARB_STATS_EN
  logic [31:0] stat_grant0;
  logic [31:0] stat_grant1;
  logic [31:0] stat_timeout;
`endif

  cache_bus_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_ARB_STATS_EN
    ,
    .stat_grant0  (stat_grant0),
    .stat_grant1  (stat_grant1),
    .stat_timeout (stat_timeout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        m0s;
    logic        m1s;
    logic        srdy;
    logic [31:0] sdin;
    logic        sstb;
    logic [31:0] saddr;
    logic        srw;
    logic        m0r;
    logic        m1r;
    logic [31:0] m0d;
    logic [31:0] m1d;
  } vec_t;

  vec_t vec [14];

  function automatic vec_t mk(input logic m0s, input logic m1s, input logic srdy,
                              input logic [31:0] sdin, input logic sstb,
                              input logic [31:0] saddr, input logic srw,
                              input logic m0r, input logic m1r,
                              input logic [31:0] m0d, input logic [31:0] m1d);
    vec_t v;
    v.m0s = m0s; v.m1s = m1s; v.srdy = srdy; v.sdin = sdin;
    v.sstb = sstb; v.saddr = saddr; v.srw = srw;
    v.m0r = m0r; v.m1r = m1r; v.m0d = m0d; v.m1d = m1d;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, return at the falling edge for sampling.
  task automatic tick(input logic m0s, input logic m1s, input logic srdy, input logic [31:0] sdin);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.m0_strobe = m0s;
    bus.m1_strobe = m1s;
    bus.S_ready   = srdy;
    bus.S_data_in = sdin;
    @(negedge clk);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.m0_strobe  = 1'b0;
    bus.m0_address = 32'h0000_0100;
    bus.m0_data_in = 32'hA5A5_A5A5;
    bus.m0_rw      = 1'b1;
    bus.m1_strobe  = 1'b0;
    bus.m1_address = 32'h0000_2000;
    bus.m1_data_in = 32'h1234_5678;
    bus.m1_rw      = 1'b0;
    bus.S_ready    = 1'b0;
    bus.S_data_in  = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1 ("rst S_strobe",    bus.S_strobe,    F);
    chk32("rst S_address",   bus.S_address,   32'h0);
    chk32("rst S_data_out",  bus.S_data_out,  32'h0);
    chk1 ("rst S_rw",        bus.S_rw,        F);
    chk1 ("rst m0_ready",    bus.m0_ready,    F);
    chk1 ("rst m1_ready",    bus.m1_ready,    F);
    chk1 ("rst m0_err",      bus.m0_err,      F);
    chk1 ("rst m1_err",      bus.m1_err,      F);
    chk32("rst m0_data_out", bus.m0_data_out, 32'h0);
    chk32("rst m1_data_out", bus.m1_data_out, 32'h0);
`ifdef CACHE_ARB_STATS_EN
    chk32("rst stat_grant0",  stat_grant0,  32'h0);
    chk32("rst stat_grant1",  stat_grant1,  32'h0);
    chk32("rst stat_timeout", stat_timeout, 32'h0);
`endif

    // Both strobe together: m0 first, then strict alternation, one read with
    // S_ready on the first BUSY cycle, writes leave data_out untouched.
    //            m0s m1s rdy sdin          sstb saddr        srw m0r m1r m0d           m1d
    vec[0]  = mk(T, T, F, 32'h0,          F, 32'h0,      F, F, F, 32'h0,         32'h0);
    vec[1]  = mk(T, T, T, 32'hDEADBEEF,   T, 32'h100,    T, F, F, 32'h0,         32'h0);
    vec[2]  = mk(T, T, F, 32'h0,          F, 32'h0,      F, T, F, 32'hDEADBEEF,  32'h0);
    vec[3]  = mk(T, T, F, 32'h0,          F, 32'h0,      F, F, F, 32'hDEADBEEF,  32'h0);
    vec[4]  = mk(T, T, T, 32'hFFFFFFFF,   T, 32'h2000,   F, F, F, 32'hDEADBEEF,  32'h0);
    vec[5]  = mk(T, T, F, 32'h0,          F, 32'h0,      F, F, T, 32'hDEADBEEF,  32'h0);
    vec[6]  = mk(T, T, F, 32'h0,          F, 32'h0,      F, F, F, 32'hDEADBEEF,  32'h0);
    vec[7]  = mk(T, T, T, 32'hCAFEF00D,   T, 32'h100,    T, F, F, 32'hDEADBEEF,  32'h0);
    vec[8]  = mk(T, T, F, 32'h0,          F, 32'h0,      F, T, F, 32'hCAFEF00D,  32'h0);
    vec[9]  = mk(T, T, F, 32'h0,          F, 32'h0,      F, F, F, 32'hCAFEF00D,  32'h0);
    vec[10] = mk(T, T, F, 32'h0,          T, 32'h2000,   F, F, F, 32'hCAFEF00D,  32'h0);
    vec[11] = mk(T, T, T, 32'h0,          T, 32'h2000,   F, F, F, 32'hCAFEF00D,  32'h0);
    vec[12] = mk(F, T, F, 32'h0,          F, 32'h0,      F, F, T, 32'hCAFEF00D,  32'h0);
    vec[13] = mk(F, F, F, 32'h0,          F, 32'h0,      F, F, F, 32'hCAFEF00D,  32'h0);

    for (int i = 0; i < 14; i++) begin
      tick(vec[i].m0s, vec[i].m1s, vec[i].srdy, vec[i].sdin);
      chk1 ($sformatf("v%0d S_strobe", i),    bus.S_strobe,    vec[i].sstb);
      chk1 ($sformatf("v%0d m0_ready", i),    bus.m0_ready,    vec[i].m0r);
      chk1 ($sformatf("v%0d m1_ready", i),    bus.m1_ready,    vec[i].m1r);
      chk1 ($sformatf("v%0d m0_err", i),      bus.m0_err,      F);
      chk1 ($sformatf("v%0d m1_err", i),      bus.m1_err,      F);
      chk32($sformatf("v%0d m0_data_out", i), bus.m0_data_out, vec[i].m0d);
      chk32($sformatf("v%0d m1_data_out", i), bus.m1_data_out, vec[i].m1d);
      if (vec[i].sstb) begin
        chk32($sformatf("v%0d S_address", i), bus.S_address, vec[i].saddr);
        chk1 ($sformatf("v%0d S_rw", i),      bus.S_rw,      vec[i].srw);
        if (!vec[i].srw) begin
          chk32($sformatf("v%0d S_data_out", i), bus.S_data_out, 32'h1234_5678);
        end
      end
    end

    // Watchdog: m0 read never acknowledged; m1 arrives during BUSY and waits.
    tick(T, F, F, 32'h0);
    chk1("to idle S_strobe", bus.S_strobe, F);
    for (int k = 1; k <= 8; k++) begin
      tick(T, (k >= 2), F, 32'h0);
      chk1($sformatf("to busy%0d S_strobe", k), bus.S_strobe, T);
      chk1($sformatf("to busy%0d m0_ready", k), bus.m0_ready, F);
    end
    tick(T, T, F, 32'h0);
    chk1 ("to done m0_ready",    bus.m0_ready,    T);
    chk1 ("to done m0_err",      bus.m0_err,      T);
    chk32("to done m0_data_out", bus.m0_data_out, 32'h0);
    chk1 ("to done S_strobe",    bus.S_strobe,    F);
    chk1 ("to done m1_ready",    bus.m1_ready,    F);
    bus.m1_rw = 1'b1;
    tick(F, T, F, 32'h0);
    chk1("to idle2 S_strobe", bus.S_strobe, F);
    chk1("to idle2 m0_err",   bus.m0_err,   F);
    tick(F, T, T, 32'h1357_9BDF);
    chk1 ("to m1 S_strobe",  bus.S_strobe,  T);
    chk32("to m1 S_address", bus.S_address, 32'h2000);
    chk1 ("to m1 S_rw",      bus.S_rw,      T);
    tick(F, T, F, 32'h0);
    chk1 ("to m1 ready",    bus.m1_ready,    T);
    chk1 ("to m1 err",      bus.m1_err,      F);
    chk32("to m1 data_out", bus.m1_data_out, 32'h1357_9BDF);
    bus.m1_rw = 1'b0;

    // m1 write held 5 BUSY cycles; read data from before must survive.
    tick(F, F, F, 32'h0);
    tick(F, T, F, 32'h0);
    chk1("wr idle S_strobe", bus.S_strobe, F);
    for (int k = 1; k <= 5; k++) begin
      tick(F, T, (k == 5), 32'hFFFF_0000);
      chk1 ($sformatf("wr busy%0d S_strobe", k),   bus.S_strobe,   T);
      chk32($sformatf("wr busy%0d S_address", k),  bus.S_address,  32'h2000);
      chk32($sformatf("wr busy%0d S_data_out", k), bus.S_data_out, 32'h1234_5678);
      chk1 ($sformatf("wr busy%0d S_rw", k),       bus.S_rw,       F);
      chk1 ($sformatf("wr busy%0d m1_ready", k),   bus.m1_ready,   F);
    end
    tick(F, T, F, 32'h0);
    chk1 ("wr done m1_ready",    bus.m1_ready,    T);
    chk1 ("wr done m1_err",      bus.m1_err,      F);
    chk32("wr done m1_data_out", bus.m1_data_out, 32'h1357_9BDF);
    chk1 ("wr done S_strobe",    bus.S_strobe,    F);
`ifdef CACHE_ARB_STATS_EN
    chk32("stat_grant0",  stat_grant0,  32'd3);
    chk32("stat_grant1",  stat_grant1,  32'd4);
    chk32("stat_timeout", stat_timeout, 32'd1);
`endif

    // Reset during the third BUSY cycle, then a clean re-request.
    tick(F, F, F, 32'h0);
    tick(T, F, F, 32'h0);
    tick(T, F, F, 32'h0);
    tick(T, F, F, 32'h0);
    tick(T, F, F, 32'h0);
    chk1("rb busy3 S_strobe", bus.S_strobe, T);
    rst = 1'b1;
    tick(T, F, F, 32'h0);
    chk1 ("rb after S_strobe",    bus.S_strobe,    F);
    chk1 ("rb after m0_ready",    bus.m0_ready,    F);
    chk1 ("rb after m0_err",      bus.m0_err,      F);
    chk32("rb after m1_data_out", bus.m1_data_out, 32'h0);
    tick(T, F, T, 32'h55AA_55AA);
    chk1 ("rb regrant S_strobe",  bus.S_strobe,  T);
    chk32("rb regrant S_address", bus.S_address, 32'h100);
    tick(T, F, F, 32'h0);
    chk1 ("rb done m0_ready",    bus.m0_ready,    T);
    chk1 ("rb done m0_err",      bus.m0_err,      F);
    chk32("rb done m0_data_out", bus.m0_data_out, 32'h55AA_55AA);
`ifdef CACHE_ARB_STATS_EN
    chk32("rb stat_grant0",  stat_grant0,  32'd1);
    chk32("rb stat_grant1",  stat_grant1,  32'd0);
    chk32("rb stat_timeout", stat_timeout, 32'd0);
`endif
    tick(F, F, F, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
